// File: rtl/serial_fifo_pkg.sv
// Shared depth defaults and drain-FSM encoding for serial_fifo and its byte queues.
package serial_fifo_pkg;

  localparam int SFIFO_TX_AW = 4;
  localparam int SFIFO_RX_AW = 4;

  typedef enum logic {
    DRAIN_IDLE = 1'b0,
    DRAIN_SEND = 1'b1
  } drain_state_t;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/serial_fifo_byte_fifo.sv
// Circular byte queue with first-word-fall-through head; a push is visible at the head one cycle later.
// When full, a push is taken only alongside an accepted pop; otherwise o_drop pulses for that cycle.
module byte_fifo
  import serial_fifo_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [7:0]    i_dat,
  input  logic          i_pop,
  output logic [7:0]    o_dat,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_drop
);

  localparam int          DEPTH    = depth_of(AW);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop && !w_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dat   = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_drop  = i_push && !w_push_ok;

endmodule

// File: rtl/serial_fifo.sv
// Byte buffering between host logic and serial_port: TX queue drained by a strobe FSM, RX queue filled by rx_stb.
// TX strobe follows a push by two cycles when the port is ready; dropped pushes on either side set sticky flags.
module serial_fifo
  import serial_fifo_pkg::*;
#(
  parameter int TX_AW = SFIFO_TX_AW,
  parameter int RX_AW = SFIFO_RX_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       tx_wr_dat,
  input  logic             tx_wr_stb,
  output logic             tx_full,
  output logic [TX_AW:0]   tx_count,
  output logic             tx_ovf,
  output logic [7:0]       rx_rd_dat,
  input  logic             rx_rd_stb,
  output logic             rx_empty,
  output logic [RX_AW:0]   rx_count,
  output logic             rx_ovf,
  input  logic             ovf_clr,
  output logic [7:0]       sp_tx_dat,
  output logic             sp_tx_stb,
  input  logic             sp_tx_rdy,
  input  logic [7:0]       sp_rx_dat,
  input  logic             sp_rx_stb
);

  drain_state_t r_state;
  logic         r_sp_tx_stb;
  logic [7:0]   r_sp_tx_dat;
  logic         r_tx_ovf;
  logic         r_rx_ovf;

  logic       w_tx_pop;
  logic       w_tx_empty;
  logic [7:0] w_tx_head;
  logic       w_tx_drop;
  logic       w_rx_drop;
  logic       w_rx_full_unused;

  byte_fifo #(.AW(TX_AW)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (tx_wr_stb),
    .i_dat   (tx_wr_dat),
    .i_pop   (w_tx_pop),
    .o_dat   (w_tx_head),
    .o_count (tx_count),
    .o_full  (tx_full),
    .o_empty (w_tx_empty),
    .o_drop  (w_tx_drop)
  );

  byte_fifo #(.AW(RX_AW)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (sp_rx_stb),
    .i_dat   (sp_rx_dat),
    .i_pop   (rx_rd_stb),
    .o_dat   (rx_rd_dat),
    .o_count (rx_count),
    .o_full  (w_rx_full_unused),
    .o_empty (rx_empty),
    .o_drop  (w_rx_drop)
  );

  // tx_rdy is only trusted in IDLE; in SEND it still reflects the pre-strobe port state.
  assign w_tx_pop = (r_state == DRAIN_IDLE) && !w_tx_empty && sp_tx_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= DRAIN_IDLE;
      r_sp_tx_stb <= 1'b0;
      r_sp_tx_dat <= 8'd0;
    end else begin
      case (r_state)
        DRAIN_IDLE: begin
          if (w_tx_pop) begin
            r_sp_tx_dat <= w_tx_head;
            r_sp_tx_stb <= 1'b1;
            r_state     <= DRAIN_SEND;
          end
        end
        DRAIN_SEND: begin
          r_sp_tx_stb <= 1'b0;
          r_state     <= DRAIN_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_ovf <= 1'b0;
      r_rx_ovf <= 1'b0;
    end else begin
      if (w_tx_drop) begin
        r_tx_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_tx_ovf <= 1'b0;
      end
      if (w_rx_drop) begin
        r_rx_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_rx_ovf <= 1'b0;
      end
    end
  end

  assign sp_tx_stb = r_sp_tx_stb;
  assign sp_tx_dat = r_sp_tx_dat;
  assign tx_ovf    = r_tx_ovf;
  assign rx_ovf    = r_rx_ovf;

endmodule
